clk_div_bank: RTL and testbench
===============================

// Module: clk_div_bank
// PURPOSE
//   Bank of CHANNELS independent programmable clock dividers.
//   Each divider makes a square wave and a one-cycle period tick from clk_in.
//   Divide ratios are runtime-loadable through a shadow register and take effect glitch-free at a period boundary.
//   A shared sync input phase-aligns all channels.
//   Serves display, sampling and PWM timing that a fixed-ratio divider cannot cover.
// PARAMETERS
//   CHANNELS     4    number of divider channels
//   DIV_WIDTH    16   width of divide ratio and per-channel counter
//   DEFAULT_DIV  4    ratio after reset, all channels (must be >= 2)
// PORTS
//   clk_in      in   1                    system clock, all logic on posedge
//   reset_n     in   1                    asynchronous reset, active-low
//   enable      in   CHANNELS             per-channel count enable
//   div_load    in   CHANNELS             per-channel strobe: capture div_value into shadow
//   div_value   in   DIV_WIDTH            new ratio, shared by all channels
//   sync        in   1                    restart all enabled channels at phase 0
//   clk_out     out  CHANNELS             divided square waves (registered)
//   tick        out  CHANNELS             1-cycle pulse at each period start (registered)
//   div_pending out  CHANNELS             shadow loaded but not yet active
// BEHAVIOUR
//   - Reset (reset_n=0, async)
//       cnt=0, clk_out=0, tick=0, div_pending=0; active=shadow=DEFAULT_DIV.
//   - Per channel, D = active ratio. On each clk_in edge with enable[i]=1:
//       * cnt==D-1: cnt<=0, clk_out<=0, tick<=1 (wrap).
//       * else: cnt<=cnt+1, tick<=0; if cnt==D/2-1 then clk_out<=1.
//       * Result: low floor(D/2) cycles, high ceil(D/2) cycles, period D.
//       * tick rises on the same edge as clk_out falls.
//       * From reset release with enable=1, first tick is on edge D.
//   - enable[i]=0: cnt and clk_out hold, tick<=0, pending load stays pending.
//   - Load
//       * div_load[i]=1: shadow<=div_value, div_pending<=1.
//       * div_value<2 is clamped to 2.
//       * Repeated loads before apply: last one wins.
//   - Apply
//       * On enabled wrap or sync with div_pending=1: active<=shadow, div_pending<=0.
//       * New D governs the period starting at that edge.
//   - Load on the same edge as an apply event: div_value (clamped) goes directly to active, div_pending<=0.
//   - Sync
//       * sync=1: every enabled channel does cnt<=0, clk_out<=0, tick<=1, applies pending.
//       * sync takes priority over normal count/wrap.
//       * Disabled channels ignore sync.
//   - Arithmetic
//       * cnt is DIV_WIDTH bits and never exceeds D-1.
//       * D/2 is floor division; max ratio is 2^DIV_WIDTH-1.
//   - Outputs never glitch: all are flops, no combinational path from inputs.
// TESTING
//   1. Reset, enable[0]=1, D=4 -> clk_out[0] 0,0,1,1 repeating; tick[0] on edges 4,8,12.
//   2. load 5 on ch1 while disabled, then enable+sync -> tick at sync edge; low 2, high 3, period 5.
//   3. ch0 D=4, load 8 at cnt=1 -> pending=1, current period ends at 4 cycles, next 8; pending clears at wrap.
//   4. load 0 and load 1 -> active becomes 2; clk_out toggles every cycle, tick every 2 cycles.
//   5. Channels at different phases, all D=6, pulse sync -> all clk_out=0 next edge, ticks coincide every 6.
//   6. reset_n low mid-period -> outputs 0 immediately without a clock; after release D=DEFAULT_DIV, pending=0.

Source files
------------

// File: rtl/clk_div_bank.sv
// clk_div_bank: a bank of independent programmable clock dividers.
// Each channel produces a registered square wave and a one-cycle tick at
// every period start. Ratios are loaded through a shadow register and only
// become active at a period boundary (wrap or sync), so no output glitches.
module clk_div_bank #(
  parameter int CHANNELS    = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic [CHANNELS-1:0]  enable,
  input  logic [CHANNELS-1:0]  div_load,
  input  logic [DIV_WIDTH-1:0] div_value,
  input  logic                 sync,
  output logic [CHANNELS-1:0]  clk_out,
  output logic [CHANNELS-1:0]  tick,
  output logic [CHANNELS-1:0]  div_pending
);

  localparam logic [DIV_WIDTH-1:0] LP_DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] LP_MIN_DIV = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] LP_ONE     = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] r_cnt    [CHANNELS];
  logic [DIV_WIDTH-1:0] r_active [CHANNELS];
  logic [DIV_WIDTH-1:0] r_shadow [CHANNELS];
  logic [CHANNELS-1:0]  r_clk;
  logic [CHANNELS-1:0]  r_tick;
  logic [CHANNELS-1:0]  r_pend;

  logic [DIV_WIDTH-1:0] w_clamped;
  logic [CHANNELS-1:0]  w_wrap;
  logic [CHANNELS-1:0]  w_rise;
  logic [CHANNELS-1:0]  w_apply;

  // Ratios below 2 cannot form a square wave, so they are forced up to 2.
  always_comb begin
    w_clamped = (div_value < LP_MIN_DIV) ? LP_MIN_DIV : div_value;
  end

  // Per-channel period decode: wrap point, rising point, and the boundary
  // event (enabled wrap or sync) at which a new ratio may take over.
  always_comb begin
    w_wrap  = '0;
    w_rise  = '0;
    w_apply = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_wrap[i]  = (r_cnt[i] == (r_active[i] - LP_ONE));
      w_rise[i]  = (r_cnt[i] == ((r_active[i] >> 1) - LP_ONE));
      w_apply[i] = enable[i] & (sync | w_wrap[i]);
    end
  end

  // Counter, output, and ratio-shadow state for every channel.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_cnt[i]    <= '0;
        r_active[i] <= LP_DEF_DIV;
        r_shadow[i] <= LP_DEF_DIV;
      end
      r_clk  <= '0;
      r_tick <= '0;
      r_pend <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_apply[i]) begin
          // Period boundary: restart at phase 0 and switch ratio if one is
          // waiting. A load on this very edge bypasses the shadow.
          r_cnt[i]  <= '0;
          r_clk[i]  <= 1'b0;
          r_tick[i] <= 1'b1;
          if (div_load[i]) begin
            r_active[i] <= w_clamped;
            r_shadow[i] <= w_clamped;
            r_pend[i]   <= 1'b0;
          end else if (r_pend[i]) begin
            r_active[i] <= r_shadow[i];
            r_pend[i]   <= 1'b0;
          end
        end else begin
          r_tick[i] <= 1'b0;
          if (div_load[i]) begin
            r_shadow[i] <= w_clamped;
            r_pend[i]   <= 1'b1;
          end
          if (enable[i]) begin
            r_cnt[i] <= r_cnt[i] + LP_ONE;
            if (w_rise[i]) begin
              r_clk[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign clk_out     = r_clk;
  assign tick        = r_tick;
  assign div_pending = r_pend;

endmodule

// File: tb/tb_clk_div_bank.sv
// Testbench for clk_div_bank: directed scenarios followed by random traffic,
// every cycle compared against a phase/ratio reference model.
module tb_clk_div_bank;

  localparam int CH = 4;
  localparam int DW = 16;
  localparam int DEF = 4;

  logic          clk_in = 1'b0;
  logic          reset_n;
  logic [CH-1:0] enable;
  logic [CH-1:0] div_load;
  logic [DW-1:0] div_value;
  logic          sync;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;
  logic [CH-1:0] div_pending;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase within period, active ratio, waiting ratio.
  int m_phase [CH];
  int m_ratio [CH];
  int m_wait  [CH];
  bit m_pend  [CH];
  bit m_tick  [CH];

  clk_div_bank #(.CHANNELS(CH), .DIV_WIDTH(DW), .DEFAULT_DIV(DEF)) dut (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .enable      (enable),
    .div_load    (div_load),
    .div_value   (div_value),
    .sync        (sync),
    .clk_out     (clk_out),
    .tick        (tick),
    .div_pending (div_pending)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_phase[i] = 0;
      m_ratio[i] = DEF;
      m_wait[i]  = DEF;
      m_pend[i]  = 1'b0;
      m_tick[i]  = 1'b0;
    end
  endtask

  // One clock edge of the specified behaviour, channel by channel.
  task automatic model_step(input logic [CH-1:0] en, input logic [CH-1:0] ld,
                            input int val, input bit sy);
    int req;
    bit boundary;
    req = (val < 2) ? 2 : val;
    for (int i = 0; i < CH; i++) begin
      boundary = en[i] && (sy || (m_phase[i] == m_ratio[i] - 1));
      if (boundary) begin
        if (ld[i]) m_ratio[i] = req;
        else if (m_pend[i]) m_ratio[i] = m_wait[i];
        m_pend[i]  = 1'b0;
        m_phase[i] = 0;
        m_tick[i]  = 1'b1;
      end else begin
        m_tick[i] = 1'b0;
        if (ld[i]) begin
          m_wait[i] = req;
          m_pend[i] = 1'b1;
        end
        if (en[i]) m_phase[i] = m_phase[i] + 1;
      end
    end
  endtask

  // Square wave is low for the first floor(D/2) phases of each period.
  function automatic logic [CH-1:0] exp_clk();
    logic [CH-1:0] v;
    for (int i = 0; i < CH; i++) v[i] = (m_phase[i] >= m_ratio[i] / 2);
    return v;
  endfunction

  function automatic logic [CH-1:0] exp_tick();
    logic [CH-1:0] v;
    for (int i = 0; i < CH; i++) v[i] = m_tick[i];
    return v;
  endfunction

  function automatic logic [CH-1:0] exp_pend();
    logic [CH-1:0] v;
    for (int i = 0; i < CH; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_clk"},  32'(clk_out),     32'(exp_clk()));
    chk({tag, "_tick"}, 32'(tick),        32'(exp_tick()));
    chk({tag, "_pend"}, 32'(div_pending), 32'(exp_pend()));
  endtask

  // Drive one cycle of inputs (called just after a rising edge), then check.
  task automatic cyc(input logic [CH-1:0] en, input logic [CH-1:0] ld,
                     input int val, input bit sy, input string tag);
    enable    = en;
    div_load  = ld;
    div_value = DW'(val);
    sync      = sy;
    @(posedge clk_in);
    #1;
    model_step(en, ld, val, sy);
    check_all(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk_in);
    #1;
    check_all("rst_hold");
    reset_n = 1'b1;
  endtask

  initial begin
    logic [CH-1:0] r_en, r_ld;
    reset_n   = 1'b1;
    enable    = '0;
    div_load  = '0;
    div_value = '0;
    sync      = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Default ratio 4 on channel 0: tick on edge 4, 8, 12.
    for (int k = 1; k <= 12; k++) begin
      cyc(4'b0001, 4'b0000, 0, 1'b0, "t1");
      if (k % 4 == 0) chk("t1_tick_edge", 32'(tick[0]), 32'd1);
    end

    // Load 5 into disabled channel 1, then enable with sync.
    cyc(4'b0001, 4'b0010, 5, 1'b0, "t2_load");
    chk("t2_pend", 32'(div_pending[1]), 32'd1);
    cyc(4'b0011, 4'b0000, 0, 1'b1, "t2_sync");
    chk("t2_sync_tick", 32'(tick[1]), 32'd1);
    chk("t2_applied", 32'(div_pending[1]), 32'd0);
    for (int k = 0; k < 10; k++) cyc(4'b0011, 4'b0000, 0, 1'b0, "t2_run");

    // Mid-period load of 8 on channel 0 stays pending until the wrap.
    cyc(4'b0011, 4'b0000, 0, 1'b1, "t3_align");
    cyc(4'b0011, 4'b0001, 8, 1'b0, "t3_load");
    chk("t3_pend", 32'(div_pending[0]), 32'd1);
    for (int k = 0; k < 20; k++) cyc(4'b0011, 4'b0000, 0, 1'b0, "t3_run");

    // Ratios 0 and 1 clamp to 2.
    cyc(4'b0011, 4'b0001, 0, 1'b0, "t4_load0");
    cyc(4'b0011, 4'b0010, 1, 1'b1, "t4_load1");
    for (int k = 0; k < 8; k++) cyc(4'b0011, 4'b0000, 0, 1'b0, "t4_run");

    // All channels at ratio 6, knocked out of phase, then re-aligned by sync.
    cyc(4'b1111, 4'b1111, 6, 1'b1, "t5_set");
    cyc(4'b0001, 4'b0000, 0, 1'b0, "t5_skew");
    cyc(4'b0011, 4'b0000, 0, 1'b0, "t5_skew");
    cyc(4'b0111, 4'b0000, 0, 1'b0, "t5_skew");
    cyc(4'b1111, 4'b0000, 0, 1'b1, "t5_sync");
    chk("t5_clk_low", 32'(clk_out), 32'd0);
    chk("t5_ticks", 32'(tick), 32'hF);
    for (int k = 0; k < 13; k++) cyc(4'b1111, 4'b0000, 0, 1'b0, "t5_run");

    // Asynchronous reset in mid-period.
    #2;
    do_reset();
    chk("t6_ratio_tick", 32'(tick), 32'd0);
    for (int k = 0; k < 8; k++) cyc(4'b1111, 4'b0000, 0, 1'b0, "t6_run");

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      r_en = 4'($urandom);
      r_en = r_en | 4'($urandom);
      r_ld = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      cyc(r_en, r_ld, int'($urandom_range(0, 11)),
          ($urandom_range(0, 29) == 0), "rnd");
      if (k == 300) begin
        #2;
        do_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
